// File: rtl/prog_seq_pkg.sv
// Shared types and constants for the program sequencer: FSM state
// encoding, program count and the fixed program base-address table.
package prog_seq_pkg;

    localparam int L_DEF = 10;
    localparam int NPROG = 3;

    // Highest valid program index; the index wraps to 0 after it.
    localparam logic [1:0] LAST_IDX = 2'(NPROG - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_RUN    = 3'd3,
        ST_DONE   = 3'd4
    } seq_state_e;

    localparam logic [L_DEF-1:0] PROG_BASE [NPROG] = '{10'd1, 10'd2, 10'd3};

    // Base address of a program; an index outside the table yields 0.
    function automatic logic [L_DEF-1:0] prog_base(input logic [1:0] idx);
        logic [L_DEF-1:0] base;
        base = '0;
        for (int i = 0; i < NPROG; i++) begin
            if (idx == 2'(i)) begin
                base = PROG_BASE[i];
            end
        end
        return base;
    endfunction

    // Program index after a halt, wrapping at the end of the table.
    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx >= LAST_IDX) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/prog_sequencer_if.sv
// Decoder/ALU/host side of the program sequencer. The master modport is the
// environment (decoder, ALU, PC register, host); the slave is the sequencer.
interface prog_sequencer_if #(
    parameter int L = 10
);
    logic         Start;
    logic         Halt;
    logic         BrAbs;
    logic         BrRel;
    logic         BrCond;
    logic         ALU_flag;
    logic [L-1:0] Target;
    logic [L-1:0] ProgCtr;
    logic         PcWrite;
    logic [L-1:0] PcNext;
    logic         Running;
    logic         Done;
    logic [1:0]   ProgIdx;
    logic         Timeout;

    modport master (
        output Start, Halt, BrAbs, BrRel, BrCond, ALU_flag, Target, ProgCtr,
        input  PcWrite, PcNext, Running, Done, ProgIdx, Timeout
    );

    modport slave (
        input  Start, Halt, BrAbs, BrRel, BrCond, ALU_flag, Target, ProgCtr,
        output PcWrite, PcNext, Running, Done, ProgIdx, Timeout
    );
endinterface

// File: rtl/prog_sequencer_pc_next_resolve.sv
// Combinational branch resolution: picks absolute target, relative
// target or PC+1 for a RUN cycle. Absolute beats relative; both are gated
// by the condition (unconditional, or ALU flag set).
module pc_next_resolve #(
    parameter int L = 10
) (
    input  logic         br_abs_i,
    input  logic         br_rel_i,
    input  logic         br_cond_i,
    input  logic         alu_flag_i,
    input  logic [L-1:0] target_i,
    input  logic [L-1:0] prog_ctr_i,
    output logic [L-1:0] next_pc_o
);
    logic cond_s;

    assign cond_s = !br_cond_i || alu_flag_i;

    // Priority mux; additions truncate naturally to L bits.
    always_comb begin
        next_pc_o = prog_ctr_i + L'(1);
        if (br_abs_i && cond_s) begin
            next_pc_o = target_i;
        end else if (br_rel_i && cond_s) begin
            next_pc_o = prog_ctr_i + target_i;
        end else begin
            next_pc_o = prog_ctr_i + L'(1);
        end
    end
endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer top: IDLE/ARMED/LAUNCH/RUN/DONE FSM owning the PC
// write enable and next-PC value, the program index and, when
// PROG_SEQ_WATCHDOG_EN is defined, a RUN-cycle watchdog.
module prog_sequencer
    import prog_seq_pkg::*;
#(
    parameter int L         = L_DEF,
    parameter int WD_CYCLES = 4096
) (
    input  logic             Clk,
    input  logic             Reset,
    prog_sequencer_if.slave  bus
);
    localparam int WD_W = (WD_CYCLES > 1) ? $clog2(WD_CYCLES) : 1;

    seq_state_e   state_q, state_d;
    logic [1:0]   prog_idx_q, prog_idx_d;
    logic         running_q, running_d;
    logic         done_q, done_d;
    logic         timeout_q, timeout_d;
    logic         pc_write_s;
    logic [L-1:0] pc_next_s;
    logic [L-1:0] branch_pc_s;
    logic         wd_expire_s;

    pc_next_resolve #(.L(L)) u_resolve (
        .br_abs_i   (bus.BrAbs),
        .br_rel_i   (bus.BrRel),
        .br_cond_i  (bus.BrCond),
        .alu_flag_i (bus.ALU_flag),
        .target_i   (bus.Target),
        .prog_ctr_i (bus.ProgCtr),
        .next_pc_o  (branch_pc_s)
    );

`ifdef PROG_SEQ_WATCHDOG_EN
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

    // Watchdog count: cleared on launch, counts every RUN cycle.
    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (state_q == ST_LAUNCH) begin
            wd_cnt_d = '0;
        end else if (state_q == ST_RUN) begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
        end else begin
            wd_cnt_d = wd_cnt_q;
        end
    end

    // Watchdog count register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end

    assign wd_expire_s = (state_q == ST_RUN) && (wd_cnt_q == WD_W'(WD_CYCLES - 1));
`else
    assign wd_expire_s = 1'b0;
`endif

    // Next state, program index, timeout flag and Mealy PC controls.
    always_comb begin
        state_d    = state_q;
        prog_idx_d = prog_idx_q;
        timeout_d  = timeout_q;
        pc_write_s = 1'b0;
        pc_next_s  = bus.ProgCtr;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.Start) begin
                    state_d = ST_ARMED;
                end else begin
                    state_d = state_q;
                end
            end
            ST_ARMED: begin
                if (!bus.Start) begin
                    state_d = ST_LAUNCH;
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_LAUNCH: begin
                pc_write_s = 1'b1;
                pc_next_s  = L'(prog_base(prog_idx_q));
                timeout_d  = 1'b0;
                state_d    = ST_RUN;
            end
            ST_RUN: begin
                if (bus.Halt) begin
                    state_d    = ST_DONE;
                    prog_idx_d = next_idx(prog_idx_q);
                end else if (wd_expire_s) begin
                    state_d    = ST_DONE;
                    prog_idx_d = next_idx(prog_idx_q);
                    timeout_d  = 1'b1;
                end else begin
                    pc_write_s = 1'b1;
                    pc_next_s  = branch_pc_s;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        running_d = (state_d == ST_RUN);
        done_d    = (state_d == ST_DONE);
    end

    // State and Moore status registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            prog_idx_q <= 2'd0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            prog_idx_q <= prog_idx_d;
            running_q  <= running_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
        end
    end

    // Reset forces the PC controls to their reset values at once, so a
    // reset landing mid-RUN never lets a branch reach the PC.
    assign bus.PcWrite = Reset ? 1'b0 : pc_write_s;
    assign bus.PcNext  = Reset ? '0 : pc_next_s;
    assign bus.Running = running_q;
    assign bus.Done    = done_q;
    assign bus.ProgIdx = prog_idx_q;
    assign bus.Timeout = timeout_q;
endmodule
